// File: rtl/lu_inv_seq.sv
// Sequencer for one LU factorisation followed by lower and upper triangular inversions.
// It pulses each engine's start, waits for the engine's ready handshake and steers the matrix muxes.
module lu_inv_seq #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       flush_i,
    input  logic       lu_in_ready_i,
    input  logic       tinv_in_ready_i,
    output logic       lu_start_o,
    output logic       tinv_start_o,
    output logic       tinv_flush_o,
    output logic [1:0] src_sel_o,
    output logic       dst_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [3:0]      START_LAST = 4'(START_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, LU_START, LU_WAIT, LI_START, LI_WAIT,
        UI_FLUSH, UI_START, UI_WAIT, DONE
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   tmo_cnt_r;
    logic [3:0]      start_cnt_r;
    logic            seen_low_r;
    logic            err_s;
    logic            in_wait_s;
    logic            in_start_s;
    logic            ready_s;
    logic            start_last_s;
    logic            wait_exit_s;
    logic            wait_tmo_s;
    logic            lu_start_s;
    logic            tinv_start_s;
    logic            tinv_flush_s;
    logic [1:0]      src_sel_s;
    logic            dst_sel_s;
    logic            busy_s;
    logic            done_s;

    // Wait/start classification; a wait exit needs a low-then-high ready from the active engine
    always_comb begin
        in_wait_s    = (state_r == LU_WAIT) || (state_r == LI_WAIT) || (state_r == UI_WAIT);
        in_start_s   = (state_r == LU_START) || (state_r == LI_START) || (state_r == UI_START);
        ready_s      = (state_r == LU_WAIT) ? lu_in_ready_i : tinv_in_ready_i;
        start_last_s = (start_cnt_r == START_LAST);
        wait_exit_s  = in_wait_s && seen_low_r && ready_s;
        wait_tmo_s   = in_wait_s && !wait_exit_s && (tmo_cnt_r == TMO_LAST);
    end

    // Next-state and sticky error; flush overrides everything and preserves err
    always_comb begin
        state_s = state_r;
        err_s   = err_o;
        if (flush_i) begin
            state_s = IDLE;
            err_s   = err_o;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_s = LU_START;
                        err_s   = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LU_START: state_s = start_last_s ? LU_WAIT : LU_START;
                LI_START: state_s = start_last_s ? LI_WAIT : LI_START;
                UI_START: state_s = start_last_s ? UI_WAIT : UI_START;
                LU_WAIT, LI_WAIT, UI_WAIT: begin
                    if (wait_exit_s) begin
                        case (state_r)
                            LU_WAIT: state_s = LI_START;
                            LI_WAIT: state_s = UI_FLUSH;
                            default: state_s = DONE;
                        endcase
                    end else if (wait_tmo_s) begin
                        state_s = IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                UI_FLUSH: state_s = UI_START;
                DONE:     state_s = IDLE;
                default:  state_s = IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state so every output comes straight from a flop
    always_comb begin
        lu_start_s   = 1'b0;
        tinv_start_s = 1'b0;
        tinv_flush_s = 1'b0;
        src_sel_s    = 2'd0;
        dst_sel_s    = 1'b0;
        busy_s       = 1'b1;
        done_s       = 1'b0;
        case (state_s)
            IDLE:     busy_s = 1'b0;
            LU_START: lu_start_s = 1'b1;
            LU_WAIT:  src_sel_s = 2'd0;
            LI_START: begin
                tinv_start_s = 1'b1;
                src_sel_s    = 2'd1;
            end
            LI_WAIT:  src_sel_s = 2'd1;
            UI_FLUSH: begin
                tinv_flush_s = 1'b1;
                src_sel_s    = 2'd2;
                dst_sel_s    = 1'b1;
            end
            UI_START: begin
                tinv_start_s = 1'b1;
                src_sel_s    = 2'd2;
                dst_sel_s    = 1'b1;
            end
            UI_WAIT: begin
                src_sel_s = 2'd2;
                dst_sel_s = 1'b1;
            end
            DONE: begin
                done_s    = 1'b1;
                src_sel_s = 2'd2;
                dst_sel_s = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            lu_start_o   <= 1'b0;
            tinv_start_o <= 1'b0;
            tinv_flush_o <= 1'b0;
            src_sel_o    <= 2'd0;
            dst_sel_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_r      <= state_s;
            lu_start_o   <= lu_start_s;
            tinv_start_o <= tinv_start_s;
            tinv_flush_o <= tinv_flush_s;
            src_sel_o    <= src_sel_s;
            dst_sel_o    <= dst_sel_s;
            busy_o       <= busy_s;
            done_o       <= done_s;
            err_o        <= err_s;
        end
    end

    // Per-state counters and seen_low flag, all restarted on any state change
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_r   <= '0;
            start_cnt_r <= 4'd0;
            seen_low_r  <= 1'b0;
        end else if (state_s != state_r) begin
            tmo_cnt_r   <= '0;
            start_cnt_r <= 4'd0;
            seen_low_r  <= 1'b0;
        end else begin
            if (in_wait_s) begin
                tmo_cnt_r  <= tmo_cnt_r + CW'(1);
                seen_low_r <= seen_low_r | ~ready_s;
            end
            if (in_start_s) begin
                start_cnt_r <= start_cnt_r + 4'd1;
            end
        end
    end

endmodule

// File: doc/lu_inv_seq.md
LU_INV_SEQ -- requirements
Module: lu_inv_seq

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2: width in cycles of each engine start pulse (legal range 1-15).
REQ-002 SHALL have parameter TIMEOUT, default 4096: maximum cycles spent in any WAIT state before abort.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  in  1  request one LU and triangular-inverse sequence.
REQ-006 SHALL have port flush_i  in  1  synchronous abort.
REQ-007 SHALL have port lu_in_ready_i  in  1  in_ready_o of the lu engine.
REQ-008 SHALL have port tinv_in_ready_i  in  1  in_ready_o of the triang_matrix_inv engine.
REQ-009 SHALL have port lu_start_o  out  1  start of the lu engine.
REQ-010 SHALL have port tinv_start_o  out  1  start of the triang_matrix_inv engine.
REQ-011 SHALL have port tinv_flush_o  out  1  one-cycle clear of the triang_matrix_inv engine between its two runs.
REQ-012 SHALL have port src_sel_o  out  2  matrix row source: 0 = input A, 1 = L, 2 = U.
REQ-013 SHALL have port dst_sel_o  out  1  inverse column destination: 0 = Linv, 1 = Uinv.
REQ-014 SHALL have port busy_o  out  1  sequence in progress.
REQ-015 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-016 SHALL have port err_o  out  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, LU_START, LU_WAIT, LI_START, LI_WAIT, UI_FLUSH, UI_START, UI_WAIT, DONE.
REQ-018 In IDLE, start_i=1 at edge T SHALL move the FSM to LU_START at T+1, clear err_o and clear the timeout counter.
REQ-019 start_i SHALL be ignored in every state except IDLE.
REQ-020 Each *_START state SHALL last exactly START_CYCLES cycles, with the matching start output high only during that state.
REQ-021 Each *_WAIT state SHALL use a seen_low flag, cleared on entry; the flag SHALL set when the engine's in_ready is 0; the state SHALL exit on the first cycle with seen_low=1 and in_ready=1.
REQ-022 In every WAIT state, in_ready=1 before any low cycle SHALL NOT end the wait.
REQ-023 Transitions SHALL be LU_WAIT -> LI_START, LI_WAIT -> UI_FLUSH (1 cycle, tinv_flush_o=1) -> UI_START, and UI_WAIT -> DONE (1 cycle, done_o=1) -> IDLE.
REQ-024 src_sel_o SHALL be 0 in IDLE/LU_*, 1 in LI_*, 2 in UI_* and in DONE.
REQ-025 dst_sel_o SHALL be 1 in UI_FLUSH/UI_*/DONE and 0 otherwise.
REQ-026 busy_o SHALL be 1 in every state except IDLE; busy_o SHALL be 1 in DONE.
REQ-027 The timeout counter, width $clog2(TIMEOUT+1), SHALL clear on every state entry and increment on each cycle spent in a WAIT state.
REQ-028 A counter value of TIMEOUT-1 without a WAIT exit SHALL set err_o and return the FSM to IDLE next cycle without a done_o pulse.
REQ-029 flush_i=1 SHALL force IDLE next cycle with all start outputs low and no done_o pulse; flush_i SHALL leave err_o unchanged.
REQ-030 flush_i SHALL take priority over start_i, over a WAIT exit and over a timeout in the same cycle.
REQ-031 If a WAIT exit and the timeout limit occur in the same cycle, the exit SHALL win and err_o SHALL stay 0.

Reset
REQ-032 With rst_ni=0, regardless of clock, the FSM SHALL go to IDLE, all outputs SHALL be 0 (src_sel_o=0, dst_sel_o=0), and counters and seen_low SHALL be 0.
REQ-033 Reset asserted mid-sequence SHALL abort with no done_o pulse.
REQ-034 The first start_i after rst_ni rises SHALL be honoured at the first clock edge.

Verification
REQ-035 Nominal: start_i pulse at cycle 0; lu_in_ready_i low at cycles 3-9; tinv_in_ready_i low at cycles 13-19 and 24-30 -> lu_start_o at cycles 1-2; tinv_start_o at 11-12 and 22-23; tinv_flush_o at 21; done_o at 32; busy_o at 1-32.
REQ-036 Stuck-ready engine: lu_in_ready_i held 1 with TIMEOUT=16 -> err_o=1 and return to IDLE after 16 LU_WAIT cycles; done_o stays 0; next start_i clears err_o.
REQ-037 Flush: flush_i at the 3rd LI_WAIT cycle -> IDLE next cycle; src_sel_o=0; busy_o=0; no done_o.
REQ-038 Ignored start: start_i pulses during LU_WAIT and UI_START -> no state change and exactly one done_o.
REQ-039 Async reset: rst_ni dropped between clock edges during UI_WAIT -> all outputs 0 immediately; a subsequent start_i restarts from LU_START.
REQ-040 Simultaneous events: tinv_in_ready_i rises on the same cycle the counter reaches TIMEOUT-1 -> DONE reached, err_o=0.
